cfgsp_access_arbiter: RTL and testbench
=======================================

# cfgsp_access_arbiter

Round-robin arbiter sharing the single configuration-space access port among `NUM_REQ` requesters: the APB slave, link-layer and DMA configuration masters. Each requester raises a request with address/data/strobe and holds them until granted. The arbiter latches the winner's payload, drives one transaction to the config space, and waits for its acknowledge. It then returns a one-cycle acknowledge, read data and error status to the owner.

## Interface

Parameters:
- DATA_WD, 32, data width.
- ADDR_WD, 16, address width.
- NUM_REQ, 4, number of requesters (2..8); requester `i` occupies slice `i` of every packed bus.
- ID_WD, 2, OWNER width; must equal clog2(NUM_REQ).
- TIMEOUT_CYC, 255, acknowledge timeout in S_CLK cycles (used only with CFGSP_ARB_TIMEOUT_EN).

Ports:
- S_CLK  in  1  sole clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-requester request level; held until that requester's GRANT bit is seen.
- REQ_ADDR  in  NUM_REQ*ADDR_WD  packed addresses.
- REQ_DATA  in  NUM_REQ*DATA_WD  packed write data.
- REQ_STRB  in  NUM_REQ*4  packed byte strobes; 4'b0000 = read.
- GRANT  out  NUM_REQ  one-hot, registered, one-cycle pulse.
- ACK  out  NUM_REQ  one-hot, registered, one-cycle completion pulse.
- RDATA  out  DATA_WD  read data of last completed read; held until next completion.
- ERR  out  1  valid with ACK; 1 = timed out.
- CS_REQ  out  1  config-space request level.
- CS_ADDR  out  ADDR_WD  latched address.
- CS_DATA  out  DATA_WD  latched write data.
- CS_STRB  out  4  latched strobes.
- CS_ACK  in  1  config-space one-cycle acknowledge.
- CS_RDATA  in  DATA_WD  read data, valid with CS_ACK.
- BUSY  out  1  high while not IDLE.
- OWNER  out  ID_WD  index of current or most recent owner.

## Operation

- Reset: every output 0, state IDLE, round-robin pointer LAST = NUM_REQ-1, timeout counter 0.
- States: IDLE, ACCESS, DONE.
- IDLE: if REQ != 0, pick the first set bit scanning LAST+1, LAST+2, …, wrapping modulo NUM_REQ. At the next edge:
  - GRANT[w] <= 1 and OWNER <= w.
  - Latch REQ_ADDR/DATA/STRB slice w into CS_ADDR/CS_DATA/CS_STRB.
  - CS_REQ <= 1, LAST <= w, go to ACCESS.
- ACCESS:
  - GRANT clears after one cycle.
  - CS_REQ and the CS_* payload stay stable.
  - REQ is ignored, including the owner's still-high REQ bit.
  - On CS_ACK: CS_REQ <= 0, ACK[OWNER] <= 1, ERR <= 0, and RDATA <= CS_RDATA if CS_STRB == 0; go to DONE.
- DONE: ACK clears, CS_ADDR/DATA/STRB <= 0, go to IDLE. This gives the owner one cycle to drop REQ.
- CS_ACK outside ACCESS is ignored; no state or output change.
- A write completion leaves RDATA unchanged.

## Timing

- REQ high in IDLE cycle 0 -> GRANT and CS_REQ high in cycle 1.
- CS_ACK sampled in cycle n -> ACK high and CS_REQ low in cycle n+1; IDLE in cycle n+2; next GRANT earliest cycle n+3.
- CS_ACK is legal in cycle 1, the first CS_REQ cycle; minimum transaction is 4 cycles from REQ to next arbitration.
- Simultaneous requests are served strictly round-robin; no requester waits more than NUM_REQ-1 transactions.
- A requester that drops REQ before being granted is simply not selected.
- PRESETn low at any point, including ACCESS with CS_REQ high, immediately forces all outputs to their reset values. The pending transaction is abandoned and no ACK is issued.

## Configuration

- CFGSP_ARB_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without CS_ACK.
  - On reaching TIMEOUT_CYC: CS_REQ <= 0, ACK[OWNER] <= 1, ERR <= 1, RDATA <= 0, go to DONE.
  - CS_ACK in the same cycle as expiry wins and yields a normal completion.
- CFGSP_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; ERR constant 0.

## Test plan

- Single write: REQ[2] with ADDR 0x0040, DATA 0xDEADBEEF, STRB 4'hF; CS_ACK 3 cycles later.
  - Required: GRANT = 4'b0100 and CS_REQ in cycle 1; CS_* = 0x0040/0xDEADBEEF/F.
  - Required: ACK = 4'b0100, ERR = 0, RDATA unchanged.
- Read: REQ[0] with STRB 0; CS_ACK with CS_RDATA 0x12345678.
  - Required: ACK[0] pulse; RDATA = 0x12345678 held through later writes.
- Fairness: REQ = 4'b1111 held, each re-raised after its ACK.
  - Required: grant order 0,1,2,3,0; then REQ = 4'b1001 after owner 3 -> grant 0.
- Back-to-back: CS_ACK in cycle 1 -> ACK in cycle 2; next GRANT no earlier than cycle 4. A spurious CS_ACK while IDLE changes nothing.
- Reset mid-ACCESS: PRESETn low with CS_REQ high.
  - Required: all outputs 0 immediately; after release, REQ = 4'b0010 -> GRANT = 4'b0010, with the pointer back at its reset value.
- Timeout (macro defined, TIMEOUT_CYC = 8): no CS_ACK for 8 ACCESS cycles.
  - Required: ACK[owner] with ERR = 1, RDATA = 0, CS_REQ low. Separately, CS_ACK on the expiry cycle -> ERR = 0.

Source files
------------

// File: rtl/cfgsp_access_arbiter_if.sv
// Request/grant and config-space bus bundle for cfgsp_access_arbiter.
// slave is the arbiter's view; master is the requester/config-space side.
interface cfgsp_access_arbiter_if #(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_WD   = 2
);
  logic [NUM_REQ-1:0]         REQ;
  logic [NUM_REQ*ADDR_WD-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_WD-1:0] REQ_DATA;
  logic [NUM_REQ*4-1:0]       REQ_STRB;
  logic [NUM_REQ-1:0]         GRANT;
  logic [NUM_REQ-1:0]         ACK;
  logic [DATA_WD-1:0]         RDATA;
  logic                       ERR;
  logic                       CS_REQ;
  logic [ADDR_WD-1:0]         CS_ADDR;
  logic [DATA_WD-1:0]         CS_DATA;
  logic [3:0]                 CS_STRB;
  logic                       CS_ACK;
  logic [DATA_WD-1:0]         CS_RDATA;
  logic                       BUSY;
  logic [ID_WD-1:0]           OWNER;

  modport slave (
    input  REQ, REQ_ADDR, REQ_DATA, REQ_STRB, CS_ACK, CS_RDATA,
    output GRANT, ACK, RDATA, ERR, CS_REQ, CS_ADDR, CS_DATA, CS_STRB, BUSY, OWNER
  );

  modport master (
    output REQ, REQ_ADDR, REQ_DATA, REQ_STRB, CS_ACK, CS_RDATA,
    input  GRANT, ACK, RDATA, ERR, CS_REQ, CS_ADDR, CS_DATA, CS_STRB, BUSY, OWNER
  );
endinterface

// File: rtl/cfgsp_access_arbiter.sv
// Round-robin owner of the single config-space port; one transaction per grant, ACK one cycle after CS_ACK.
// Define CFGSP_ARB_TIMEOUT_EN to complete an unacknowledged access after TIMEOUT_CYC cycles with ERR=1.
module cfgsp_access_arbiter #(
  parameter int DATA_WD     = 32,
  parameter int ADDR_WD     = 16,
  parameter int NUM_REQ     = 4,
  parameter int ID_WD       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  S_CLK,
  input  logic                  PRESETn,
  cfgsp_access_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_WD != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("cfgsp_access_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_WD-1:0]   rdata_q, rdata_d;
  logic                 cs_req_q, cs_req_d;
  logic [ADDR_WD-1:0]   cs_addr_q, cs_addr_d;
  logic [DATA_WD-1:0]   cs_data_q, cs_data_d;
  logic [3:0]           cs_strb_q, cs_strb_d;
  logic [ID_WD-1:0]     owner_q, owner_d;
  logic [ID_WD-1:0]     last_q, last_d;
  logic [ID_WD:0]       pick;
  logic [ID_WD-1:0]     win;

`ifdef CFGSP_ARB_TIMEOUT_EN
  localparam int CNT_WD = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_WD-1:0]    cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  // Scan last+1, last+2, ... downwards so the nearest set bit is the one left standing.
  function automatic logic [ID_WD:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [ID_WD-1:0]   last);
    logic [ID_WD:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) res = {1'b1, ID_WD'(idx)};
    end
    return res;
  endfunction

  assign pick = rr_pick(bus.REQ, last_q);
  assign win  = pick[ID_WD-1:0];

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    ack_d     = '0;
    rdata_d   = rdata_q;
    cs_req_d  = cs_req_q;
    cs_addr_d = cs_addr_q;
    cs_data_d = cs_data_q;
    cs_strb_d = cs_strb_q;
    owner_d   = owner_q;
    last_d    = last_q;
`ifdef CFGSP_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick[ID_WD]) begin
          grant_d[win] = 1'b1;
          owner_d      = win;
          last_d       = win;
          cs_req_d     = 1'b1;
          cs_addr_d    = bus.REQ_ADDR[win*ADDR_WD +: ADDR_WD];
          cs_data_d    = bus.REQ_DATA[win*DATA_WD +: DATA_WD];
          cs_strb_d    = bus.REQ_STRB[win*4 +: 4];
`ifdef CFGSP_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // REQ is deliberately not looked at here, the owner's bit may still be high.
        if (bus.CS_ACK) begin
          cs_req_d       = 1'b0;
          ack_d[owner_q] = 1'b1;
          if (cs_strb_q == 4'b0000) rdata_d = bus.CS_RDATA;
`ifdef CFGSP_ARB_TIMEOUT_EN
          err_d          = 1'b0;
`endif
          state_d        = S_DONE;
        end
`ifdef CFGSP_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_WD'(TIMEOUT_CYC - 1)) begin
          cs_req_d       = 1'b0;
          ack_d[owner_q] = 1'b1;
          err_d          = 1'b1;
          rdata_d        = '0;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        cs_addr_d = '0;
        cs_data_d = '0;
        cs_strb_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_CLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      cs_req_q  <= 1'b0;
      cs_addr_q <= '0;
      cs_data_q <= '0;
      cs_strb_q <= '0;
      owner_q   <= '0;
      last_q    <= ID_WD'(NUM_REQ - 1);
`ifdef CFGSP_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      cs_req_q  <= cs_req_d;
      cs_addr_q <= cs_addr_d;
      cs_data_q <= cs_data_d;
      cs_strb_q <= cs_strb_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
`ifdef CFGSP_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.GRANT   = grant_q;
  assign bus.ACK     = ack_q;
  assign bus.RDATA   = rdata_q;
  assign bus.CS_REQ  = cs_req_q;
  assign bus.CS_ADDR = cs_addr_q;
  assign bus.CS_DATA = cs_data_q;
  assign bus.CS_STRB = cs_strb_q;
  assign bus.OWNER   = owner_q;
  assign bus.BUSY    = (state_q != S_IDLE);
`ifdef CFGSP_ARB_TIMEOUT_EN
  assign bus.ERR     = err_q;
`else
  assign bus.ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_cfgsp_access_arbiter.sv
// Self-checking bench for cfgsp_access_arbiter: vector table, hand-written corner sequences, random traffic vs. model.
module tb_cfgsp_access_arbiter;

  logic S_CLK;
  logic PRESETn;
  int   n_chk  = 0;
  int   n_fail = 0;

  cfgsp_access_arbiter_if #(.DATA_WD(32), .ADDR_WD(16), .NUM_REQ(4), .ID_WD(2)) bus ();

  cfgsp_access_arbiter #(
    .DATA_WD(32), .ADDR_WD(16), .NUM_REQ(4), .ID_WD(2), .TIMEOUT_CYC(8)
  ) dut (
    .S_CLK  (S_CLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  logic [15:0] p_addr [4];
  logic [31:0] p_data [4];
  logic [3:0]  p_strb [4];

  typedef struct {
    int          req_i;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;
    logic [31:0] cs_rd;
    logic [3:0]  exp_gnt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_payload();
    for (int i = 0; i < 4; i++) begin
      bus.REQ_ADDR[i*16 +: 16] = p_addr[i];
      bus.REQ_DATA[i*32 +: 32] = p_data[i];
      bus.REQ_STRB[i*4 +: 4]   = p_strb[i];
    end
  endtask

  // Round-robin rule: first requesting index after the last owner, wrapping.
  function automatic int model_pick(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++)
      if (mask[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  64'(bus.GRANT),   0);
    chk({tag, "_ack"},    64'(bus.ACK),     0);
    chk({tag, "_rdata"},  64'(bus.RDATA),   0);
    chk({tag, "_err"},    64'(bus.ERR),     0);
    chk({tag, "_cs_req"}, 64'(bus.CS_REQ),  0);
    chk({tag, "_cs_addr"},64'(bus.CS_ADDR), 0);
    chk({tag, "_cs_data"},64'(bus.CS_DATA), 0);
    chk({tag, "_cs_strb"},64'(bus.CS_STRB), 0);
    chk({tag, "_busy"},   64'(bus.BUSY),    0);
    chk({tag, "_owner"},  64'(bus.OWNER),   0);
  endtask

  // Starts from an IDLE negedge; returns at the first ACCESS negedge with REQ dropped.
  task automatic grant_phase(input logic [3:0] mask, input logic [3:0] exp_gnt);
    int w = 0;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) w = i;
    bus.REQ = mask;
    @(negedge S_CLK);
    chk("grant",   64'(bus.GRANT),   64'(exp_gnt));
    chk("cs_req",  64'(bus.CS_REQ),  1);
    chk("busy",    64'(bus.BUSY),    1);
    chk("owner",   64'(bus.OWNER),   64'(w));
    chk("cs_addr", 64'(bus.CS_ADDR), 64'(p_addr[w]));
    chk("cs_data", 64'(bus.CS_DATA), 64'(p_data[w]));
    chk("cs_strb", 64'(bus.CS_STRB), 64'(p_strb[w]));
    bus.REQ = '0;
  endtask

  task automatic ack_phase(input logic [31:0] rd, input logic [3:0] exp_gnt, input logic [31:0] exp_rd);
    bus.CS_ACK   = 1'b1;
    bus.CS_RDATA = rd;
    @(negedge S_CLK);
    bus.CS_ACK   = 1'b0;
    chk("ack",        64'(bus.ACK),    64'(exp_gnt));
    chk("ack_err",    64'(bus.ERR),    0);
    chk("ack_cs_req", 64'(bus.CS_REQ), 0);
    chk("rdata",      64'(bus.RDATA),  64'(exp_rd));
    @(negedge S_CLK);
    chk("done_ack",     64'(bus.ACK),     0);
    chk("done_busy",    64'(bus.BUSY),    0);
    chk("done_cs_addr", 64'(bus.CS_ADDR), 0);
    chk("done_cs_strb", 64'(bus.CS_STRB), 0);
  endtask

  task automatic txn(input logic [3:0] mask, input int delay, input logic [31:0] rd,
                     input logic [3:0] exp_gnt, input logic [31:0] exp_rd);
    grant_phase(mask, exp_gnt);
    for (int d = 0; d < delay; d++) begin
      @(negedge S_CLK);
      chk("hold_grant",  64'(bus.GRANT),  0);
      chk("hold_cs_req", 64'(bus.CS_REQ), 1);
    end
    ack_phase(rd, exp_gnt, exp_rd);
  endtask

  task automatic spurious_ack(input logic [31:0] exp_rd);
    bus.CS_ACK   = 1'b1;
    bus.CS_RDATA = $urandom;
    @(negedge S_CLK);
    bus.CS_ACK   = 1'b0;
    chk("spur_ack",    64'(bus.ACK),    0);
    chk("spur_rdata",  64'(bus.RDATA),  64'(exp_rd));
    chk("spur_busy",   64'(bus.BUSY),   0);
    chk("spur_cs_req", 64'(bus.CS_REQ), 0);
  endtask

  initial begin
    int          m_last;
    logic [31:0] m_rd;
    logic [3:0]  mask;
    logic [31:0] rd;
    int          w;

    vecs[0] = '{2, 16'h0040, 32'hDEADBEEF, 4'hF, 3, 32'hBAD0BAD0, 4'b0100, 32'h0};
    vecs[1] = '{0, 16'h0010, 32'h00000000, 4'h0, 1, 32'h12345678, 4'b0001, 32'h12345678};
    vecs[2] = '{1, 16'h0104, 32'hCAFEF00D, 4'h3, 0, 32'hFFFFFFFF, 4'b0010, 32'h12345678};
    vecs[3] = '{3, 16'h0FFC, 32'h01020304, 4'hC, 2, 32'h00000000, 4'b1000, 32'h12345678};
    vecs[4] = '{3, 16'h0200, 32'h00000000, 4'h0, 0, 32'hA5A55A5A, 4'b1000, 32'hA5A55A5A};

    PRESETn      = 1'b0;
    bus.REQ      = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_DATA = '0;
    bus.REQ_STRB = '0;
    bus.CS_ACK   = 1'b0;
    bus.CS_RDATA = '0;
    repeat (2) @(negedge S_CLK);
    chk_all_zero("rst");
    PRESETn = 1'b1;
    @(negedge S_CLK);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        p_addr[i] = '0; p_data[i] = '0; p_strb[i] = 4'hF;
      end
      p_addr[vecs[v].req_i] = vecs[v].addr;
      p_data[vecs[v].req_i] = vecs[v].data;
      p_strb[vecs[v].req_i] = vecs[v].strb;
      load_payload();
      txn(4'(1 << vecs[v].req_i), vecs[v].delay, vecs[v].cs_rd, vecs[v].exp_gnt, vecs[v].exp_rd);
    end

    // Fairness: all four requesting, then 1001 after owner 3.
    for (int i = 0; i < 4; i++) begin
      p_addr[i] = 16'h0100 + 16'(i); p_data[i] = 32'h1000 + 32'(i); p_strb[i] = 4'hF;
    end
    load_payload();
    for (int i = 0; i < 4; i++) txn(4'b1111, i, $urandom, 4'(1 << i), 32'hA5A55A5A);
    txn(4'b1001, 1, $urandom, 4'b0001, 32'hA5A55A5A);

    // Back-to-back: CS_ACK in the first CS_REQ cycle, requester 0 holding REQ throughout.
    bus.REQ = 4'b0001;
    @(negedge S_CLK);
    chk("b2b_grant1", 64'(bus.GRANT), 4'b0001);
    bus.CS_ACK = 1'b1;
    @(negedge S_CLK);
    bus.CS_ACK = 1'b0;
    chk("b2b_ack",    64'(bus.ACK),   4'b0001);
    chk("b2b_gnt_c2", 64'(bus.GRANT), 0);
    @(negedge S_CLK);
    chk("b2b_gnt_c3", 64'(bus.GRANT), 0);
    chk("b2b_idle",   64'(bus.BUSY),  0);
    @(negedge S_CLK);
    chk("b2b_grant4", 64'(bus.GRANT), 4'b0001);
    bus.REQ = '0;
    ack_phase($urandom, 4'b0001, 32'hA5A55A5A);
    spurious_ack(32'hA5A55A5A);

    // Reset while requester 1 owns the port; pointer must return to NUM_REQ-1.
    grant_phase(4'b0010, 4'b0010);
    PRESETn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge S_CLK);
    PRESETn = 1'b1;
    @(negedge S_CLK);
    chk("post_rst_ack", 64'(bus.ACK), 0);
    txn(4'b0110, 1, $urandom, 4'b0010, 32'h0);

    // Requester 2 access left unacknowledged.
    grant_phase(4'b0100, 4'b0100);
`ifdef CFGSP_ARB_TIMEOUT_EN
    repeat (7) @(negedge S_CLK);
    chk("to_pending", 64'(bus.CS_REQ), 1);
    @(negedge S_CLK);
    chk("to_ack",    64'(bus.ACK),    4'b0100);
    chk("to_err",    64'(bus.ERR),    1);
    chk("to_rdata",  64'(bus.RDATA),  0);
    chk("to_cs_req", 64'(bus.CS_REQ), 0);
    @(negedge S_CLK);
    chk("to_idle",   64'(bus.BUSY),   0);
    grant_phase(4'b0100, 4'b0100);
    repeat (7) @(negedge S_CLK);
    ack_phase($urandom, 4'b0100, 32'h0);
`else
    repeat (20) @(negedge S_CLK);
    chk("nto_cs_req", 64'(bus.CS_REQ), 1);
    chk("nto_ack",    64'(bus.ACK),    0);
    chk("nto_busy",   64'(bus.BUSY),   1);
    ack_phase($urandom, 4'b0100, 32'h0);
`endif

    m_last = 2;
    m_rd   = 32'h0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) spurious_ack(m_rd);
      for (int i = 0; i < 4; i++) begin
        p_addr[i] = 16'($urandom);
        p_data[i] = $urandom;
        p_strb[i] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      load_payload();
      mask   = 4'($urandom_range(1, 15));
      w      = model_pick(mask, m_last);
      m_last = w;
      rd     = $urandom;
      if (p_strb[w] == 4'h0) m_rd = rd;
      txn(mask, $urandom_range(0, 5), rd, 4'(1 << w), m_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
